// File: rtl/cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm
//
// Fills one cache block after a lookup miss. It issues one word read per
// cycle to the RAM controller, writes each returned word into the data array
// in request order, writes the tag with the last word, and pulses fill_done.
//
// Optional feature macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN
//   defined   : requests/returns start at the missing word's offset and wrap
//   undefined : requests/returns start at offset 0 and ascend
//
// Ports
//   clk               in   single clock, rising edge
//   rst               in   synchronous active-high reset
//   miss_detected     in   lookup missed (held by the cache until fill_done)
//   miss_address      in   16-bit byte address of the missing access
//   fsm_busy          out  pipeline stall, fill start through fill_done cycle
//   memory_enable     out  one-cycle word read request
//   memory_address    out  byte address of the requested word
//   memory_data_valid in   a returned word is present this cycle
//   memory_data_in    in   returned word
//   write_data_array  out  write data_word at data_offset
//   data_offset       out  word offset within the block for the data write
//   data_word         out  word to write (memory_data_in, combinational)
//   write_tag_array   out  write tag/valid for the block
//   fill_done         out  one-cycle completion pulse
// ----------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_detected,
    input  logic [15:0]      miss_address,
    output logic             fsm_busy,
    output logic             memory_enable,
    output logic [15:0]      memory_address,
    input  logic             memory_data_valid,
    input  logic [15:0]      memory_data_in,
    output logic             write_data_array,
    output logic [OFF_W-1:0] data_offset,
    output logic [15:0]      data_word,
    output logic             write_tag_array,
    output logic             fill_done
);

    localparam int CNT_W = OFF_W + 1;
    localparam int BLK_W = 15 - OFF_W;
    localparam logic [CNT_W-1:0] WORDS     = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [BLK_W-1:0] blk_reg;        // block-aligned part of the base address
    logic [OFF_W-1:0] start_off_reg;  // first word offset of this fill
    logic [CNT_W-1:0] req_cnt_reg;    // requests issued so far
    logic [CNT_W-1:0] ret_cnt_reg;    // words returned so far

    logic [OFF_W-1:0] start_off_next;
    logic [OFF_W-1:0] req_off;
    logic [OFF_W-1:0] ret_off;
    logic             in_fill;
    logic             req_fire;
    logic             ret_fire;
    logic             ret_last;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_off_next = miss_address[OFF_W:1];
`else
    assign start_off_next = '0;
`endif

    // Low address bits only select the starting word (or nothing at all).
    logic unused_addr_bits;
    assign unused_addr_bits = ^miss_address[OFF_W:0];

    // OFF_W-bit additions wrap modulo the block size, so the generated
    // address never carries out of the block.
    assign req_off = start_off_reg + req_cnt_reg[OFF_W-1:0];
    assign ret_off = start_off_reg + ret_cnt_reg[OFF_W-1:0];

    // Outputs are gated with rst so they read 0 during the reset cycle too,
    // regardless of the state left over from an interrupted fill.
    assign in_fill  = !rst && (state_reg == ST_FILL);
    assign req_fire = in_fill && (req_cnt_reg < WORDS);
    assign ret_fire = in_fill && memory_data_valid && (ret_cnt_reg < WORDS);
    assign ret_last = ret_fire && (ret_cnt_reg == LAST_WORD);

    assign fsm_busy         = !rst && (state_reg != ST_IDLE);
    assign memory_enable    = req_fire;
    assign memory_address   = req_fire ? {blk_reg, req_off, 1'b0} : 16'd0;
    assign write_data_array = ret_fire;
    assign data_offset      = ret_fire ? ret_off : '0;
    assign data_word        = memory_data_in;
    assign write_tag_array  = ret_last;
    assign fill_done        = !rst && (state_reg == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            blk_reg       <= '0;
            start_off_reg <= '0;
            req_cnt_reg   <= '0;
            ret_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (miss_detected) begin
                        state_reg     <= ST_FILL;
                        blk_reg       <= miss_address[15:OFF_W+1];
                        start_off_reg <= start_off_next;
                        req_cnt_reg   <= '0;
                        ret_cnt_reg   <= '0;
                    end
                end
                ST_FILL: begin
                    // miss_detected is deliberately not looked at here: once
                    // started, a fill always runs to completion.
                    if (req_fire) begin
                        req_cnt_reg <= req_cnt_reg + 1'b1;
                    end
                    if (ret_fire) begin
                        ret_cnt_reg <= ret_cnt_reg + 1'b1;
                    end
                    if (ret_last) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Always pass through IDLE so back-to-back misses are
                    // separated by at least one idle cycle.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// tb_cache_fill_fsm
//
// Directed bench for cache_fill_fsm (WORDS_PER_BLOCK = 8). A per-cycle vector
// table covers reset, a stray valid in IDLE, a zero-latency fill, the DONE
// cycle and the mandatory IDLE cycle before the next fill. Hand-written fill
// sequences cover fixed latency, irregular return gaps, reset mid-fill and
// miss_detected dropping during the fill.
// ----------------------------------------------------------------------------
module tb_cache_fill_fsm;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'd0;
    logic        fsm_busy;
    logic        memory_enable;
    logic [15:0] memory_address;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data_in = 16'd0;
    logic        write_data_array;
    logic [2:0]  data_offset;
    logic [15:0] data_word;
    logic        write_tag_array;
    logic        fill_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_fill_fsm #(.WORDS_PER_BLOCK(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .fsm_busy         (fsm_busy),
        .memory_enable    (memory_enable),
        .memory_address   (memory_address),
        .memory_data_valid(memory_data_valid),
        .memory_data_in   (memory_data_in),
        .write_data_array (write_data_array),
        .data_offset      (data_offset),
        .data_word        (data_word),
        .write_tag_array  (write_tag_array),
        .fill_done        (fill_done)
    );

    typedef struct {
        logic        rst;
        logic        miss;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] din;
        logic        e_busy;
        logic        e_en;
        logic [15:0] e_ma;
        logic        e_wr;
        logic [2:0]  e_off;
        logic        e_tag;
        logic        e_done;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic busy, input logic en,
                              input logic [15:0] ma, input logic wr, input logic [2:0] off,
                              input logic tg, input logic done);
        chk({tag, ".fsm_busy"},         16'(fsm_busy),         16'(busy));
        chk({tag, ".memory_enable"},    16'(memory_enable),    16'(en));
        chk({tag, ".memory_address"},   memory_address,        ma);
        chk({tag, ".write_data_array"}, 16'(write_data_array), 16'(wr));
        chk({tag, ".data_offset"},      16'(data_offset),      16'(off));
        chk({tag, ".write_tag_array"},  16'(write_tag_array),  16'(tg));
        chk({tag, ".fill_done"},        16'(fill_done),        16'(done));
        chk({tag, ".data_word"},        data_word,             memory_data_in);
    endtask

    function automatic vec_t mk(input logic r, input logic m, input logic [15:0] a,
                                input logic v, input logic [15:0] d,
                                input logic busy, input logic en, input logic [15:0] ma,
                                input logic wr, input logic [2:0] off,
                                input logic tg, input logic done);
        vec_t t;
        t.rst = r; t.miss = m; t.addr = a; t.valid = v; t.din = d;
        t.e_busy = busy; t.e_en = en; t.e_ma = ma; t.e_wr = wr;
        t.e_off = off; t.e_tag = tg; t.e_done = done;
        return t;
    endfunction

    task automatic reset_dut();
        rst = 1'b1; miss_detected = 1'b0; memory_data_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_outs("post_reset", 0, 0, 16'd0, 0, 3'd0, 0, 0);
        @(posedge clk); #1;
    endtask

    // One complete fill. sched[] lists the cycles (0 = first FILL cycle) on
    // which memory_data_valid is driven. rst_after >= 0 asserts reset on the
    // first cycle after that many words have been written.
    task automatic do_fill(input string name, input logic [15:0] addr, input int sched[8],
                           input int rst_after, input bit drop_miss);
        int          so;
        int          ret;
        int          last_sched;
        bit          aborted;
        bit          finished;
        bit          v;
        logic [15:0] base;
        logic [2:0]  e_off;
        so       = CWF ? int'(addr[3:1]) : 0;
        base     = addr & 16'hFFF0;
        ret      = 0;
        aborted  = 1'b0;
        finished = 1'b0;
        last_sched = 0;
        for (int j = 0; j < 8; j++) if (sched[j] > last_sched) last_sched = sched[j];

        miss_detected = 1'b1; miss_address = addr; memory_data_valid = 1'b0;
        @(negedge clk);
        check_outs({name, ".idle"}, 0, 0, 16'd0, 0, 3'd0, 0, 0);
        @(posedge clk); #1;

        for (int c = 0; c < 80 && !finished; c++) begin
            v = 1'b0;
            for (int j = 0; j < 8; j++) if (sched[j] == c) v = 1'b1;
            miss_detected     = (aborted || (drop_miss && c >= 1)) ? 1'b0 : 1'b1;
            memory_data_valid = v;
            memory_data_in    = 16'hD000 + 16'(c);
            rst = (!aborted && rst_after >= 0 && ret == rst_after) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (rst || aborted) begin
                check_outs({name, ".aborted"}, 0, 0, 16'd0, 0, 3'd0, 0, 0);
                aborted = 1'b1;
            end else begin
                e_off = 3'((so + ret) % 8);
                check_outs({name, ".fill"}, 1, (c < 8),
                           (c < 8) ? base + 16'(2 * ((so + c) % 8)) : 16'd0,
                           v, v ? e_off : 3'd0, v && (ret == 7), 0);
                if (v) ret++;
            end
            @(posedge clk); #1;
            rst = 1'b0;
            if (!aborted && ret == 8) finished = 1'b1;
            if (aborted && c >= last_sched) finished = 1'b1;
        end

        memory_data_valid = 1'b0;
        miss_detected     = 1'b0;
        if (!finished) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.timeout: got %0d words expected 8", name, ret);
        end else if (!aborted) begin
            @(negedge clk);
            check_outs({name, ".done"}, 1, 0, 16'd0, 0, 3'd0, 0, 1);
            @(posedge clk); #1;
            @(negedge clk);
            check_outs({name, ".after"}, 0, 0, 16'd0, 0, 3'd0, 0, 0);
            @(posedge clk); #1;
        end else begin
            chk({name, ".words_before_reset"}, 16'(ret), 16'(rst_after));
        end
    endtask

    initial begin
        int so1;
        int so2;
        int sched[8];
        int t;
        int gaps[7];

        // ---------------- vector table ----------------
        so1 = CWF ? 3 : 0;   // 0x1236 -> word 3
        so2 = CWF ? 1 : 0;   // 0x4002 -> word 1
        tbl[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 0, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 1, 16'hAAAA, 0, 0, 16'h0000, 0, 3'd0, 0, 0);
        tbl[2]  = mk(0, 1, 16'h1236, 0, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            tbl[3 + k] = mk(0, 1, 16'h1236, 1, 16'h1000 + 16'(k),
                            1, 1, 16'h1230 + 16'(2 * ((so1 + k) % 8)),
                            1, 3'((so1 + k) % 8), (k == 7), 0);
        end
        tbl[11] = mk(0, 1, 16'h1236, 1, 16'h5555, 1, 0, 16'h0000, 0, 3'd0, 0, 1);
        tbl[12] = mk(0, 1, 16'h4002, 0, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 0, 0);
        tbl[13] = mk(0, 0, 16'h4002, 0, 16'h0000, 1, 1, 16'h4000 + 16'(2 * so2),
                     0, 3'd0, 0, 0);

        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) begin
            rst               = tbl[i].rst;
            miss_detected     = tbl[i].miss;
            miss_address      = tbl[i].addr;
            memory_data_valid = tbl[i].valid;
            memory_data_in    = tbl[i].din;
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), tbl[i].e_busy, tbl[i].e_en, tbl[i].e_ma,
                       tbl[i].e_wr, tbl[i].e_off, tbl[i].e_tag, tbl[i].e_done);
            $display("vec %0d: busy=%0b en=%0b addr=%h wr=%0b off=%0d tag=%0b done=%0b",
                     i, fsm_busy, memory_enable, memory_address, write_data_array,
                     data_offset, write_tag_array, fill_done);
            @(posedge clk); #1;
        end

        // ---------------- hand sequences ----------------
        reset_dut();
        for (int k = 0; k < 8; k++) sched[k] = k + 4;
        do_fill("lat4", 16'h1236, sched, -1, 1'b0);
        $display("seq lat4 done: miscompares so far %0d", n_err);

        do_fill("cwf", 16'h123A, sched, -1, 1'b0);
        $display("seq cwf done: miscompares so far %0d", n_err);

        gaps = '{0, 3, 7, 0, 3, 7, 0};
        t = 0;
        sched[0] = 0;
        for (int k = 1; k < 8; k++) begin
            t = t + 1 + gaps[k - 1];
            sched[k] = t;
        end
        do_fill("gaps", 16'h7F3E, sched, -1, 1'b0);
        $display("seq gaps done: miscompares so far %0d", n_err);

        for (int k = 0; k < 8; k++) sched[k] = k + 1;
        do_fill("rst_mid", 16'h2468, sched, 3, 1'b0);
        $display("seq rst_mid done: miscompares so far %0d", n_err);

        for (int k = 0; k < 8; k++) sched[k] = k + 2;
        do_fill("drop_miss", 16'hBEEC, sched, -1, 1'b1);
        $display("seq drop_miss done: miscompares so far %0d", n_err);

        // Stray valid in IDLE after everything
        memory_data_valid = 1'b1; memory_data_in = 16'h0F0F;
        @(negedge clk);
        check_outs("stray_idle", 0, 0, 16'd0, 0, 3'd0, 0, 0);
        $display("seq stray_idle: wr=%0b", write_data_array);
        @(posedge clk); #1;
        memory_data_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have parameter WORDS_PER_BLOCK, default 8, meaning 16-bit words per cache block; legal values are powers of two from 2 to 8. OFF_W = log2(WORDS_PER_BLOCK).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port miss_detected, input, 1, cache lookup missed; held by the cache until fill_done.
REQ-005 SHALL have port miss_address, input, 16, byte address of the missing access.
REQ-006 SHALL have port fsm_busy, output, 1, pipeline stall; high from fill start through the fill_done cycle.
REQ-007 SHALL have port memory_enable, output, 1, one-cycle word read request to the RAM controller.
REQ-008 SHALL have port memory_address, output, 16, byte address of the requested word.
REQ-009 SHALL have port memory_data_valid, input, 1, a returned word is present this cycle.
REQ-010 SHALL have port memory_data_in, input, 16, returned word.
REQ-011 SHALL have port write_data_array, output, 1, write data_word at data_offset into the cache data array.
REQ-012 SHALL have port data_offset, output, OFF_W, word offset within the block for the data write.
REQ-013 SHALL have port data_word, output, 16, the word to write; equals memory_data_in combinationally.
REQ-014 SHALL have port write_tag_array, output, 1, write the tag and valid bit for the block.
REQ-015 SHALL have port fill_done, output, 1, one-cycle pulse when the block is complete.

Function
REQ-016 SHALL implement states IDLE, FILL and DONE.
REQ-017 IDLE -> FILL SHALL occur on a cycle with miss_detected=1; base = miss_address with bits [OFF_W:0] cleared, latched at that edge.
REQ-018 In FILL, the block SHALL issue exactly WORDS_PER_BLOCK requests on consecutive cycles, starting in the first FILL cycle: memory_enable=1, memory_address = base + 2*req_offset.
REQ-019 The request counter SHALL count issued requests; memory_enable SHALL be 0 once all requests are issued.
REQ-020 Each memory_data_valid in FILL SHALL assert write_data_array in the same cycle, with data_offset = offset of the oldest unreturned request (in-order return), and SHALL advance the return counter.
REQ-021 On the valid that returns the last word, write_tag_array SHALL also be 1 in the same cycle; the next state SHALL be DONE.
REQ-022 DONE SHALL last one cycle with fill_done=1 and fsm_busy=1, then go to IDLE.
REQ-023 memory_data_valid in IDLE or DONE, or after all words have returned, SHALL be ignored (no array writes).
REQ-024 Deassertion of miss_detected during FILL SHALL NOT abort the fill.
REQ-025 A miss_detected held high in DONE SHALL start a new fill only from IDLE (minimum one IDLE cycle between fills).
REQ-026 Offset arithmetic SHALL wrap modulo WORDS_PER_BLOCK; the address carry SHALL never leave the block.
REQ-027 Memory latency SHALL NOT be assumed; any valid timing at or after the request cycle SHALL be correct.

Reset
REQ-028 When rst=1 at an edge, state SHALL become IDLE, both counters 0, and base 0.
REQ-029 During and after reset, all outputs SHALL be 0 except data_word, which follows memory_data_in.
REQ-030 Reset mid-FILL SHALL discard the partial fill without a tag write; stale valids arriving afterwards SHALL be ignored per REQ-023.

Configuration
REQ-031 Macro CACHE_FILL_CRITICAL_WORD_FIRST_EN, when defined, SHALL start requests and returns at offset miss_address[OFF_W:1] and wrap around (e.g. 5,6,7,0..4).
REQ-032 Without the macro, requests and returns SHALL start at offset 0 and ascend.

Verification
REQ-033 Macro off, miss_address=0x1236, valids 4 cycles after each request -> memory_address 0x1230..0x123E on 8 consecutive cycles; 8 writes at offsets 0..7; tag write with the 8th; fill_done one cycle later.
REQ-034 Macro on, miss_address=0x123A -> addresses 0x123A,0x123C,0x123E,0x1230..0x1238; data_offset sequence 5,6,7,0,1,2,3,4.
REQ-035 Irregular valid gaps (0, 3 and 7 idle cycles) -> exactly 8 writes, in order, with no lost or duplicated offsets.
REQ-036 rst=1 after the 3rd returned word -> outputs 0 the next cycle, no tag write; the remaining 5 valids cause no writes.
REQ-037 miss_detected dropped in the 2nd FILL cycle -> fill still completes with 8 writes and fill_done.
REQ-038 Stray memory_data_valid in IDLE -> write_data_array stays 0.
